// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for pipeline stage buffers
//
// Purpose: state encoding for the valid/ready stage buffer, the default
// bubble bundle, and a helper that maps state to an entry count.
// Ports: none (package).

package pipe_pkg;

  // Stage fill state; the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  // Bubble bundle presented while the stage holds nothing.
  localparam logic [63:0] NOP_BUNDLE = 64'h0;

  // Entries held for a given state (0..2). The unused encoding reports 0.
  function automatic logic [1:0] occ_of(input pipe_state_e st);
    logic [1:0] n;
    n = 2'd0;
    case (st)
      ST_EMPTY: n = 2'd0;
      ST_ONE:   n = 2'd1;
      ST_TWO:   n = 2'd2;
      default:  n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - valid/ready pipeline stage with 2-entry skid buffer
//
// Purpose: registered hand-off between two pipeline stages carrying an
// opaque DATA_W bundle. The skid entry absorbs the one beat that can arrive
// while the consumer is stalling, so in_ready is derived only from local
// state and never from out_ready.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   freeze     in   hold all state, no transfers on either side
//   flush      in   discard all held entries (synchronous)
//   in_valid   in   producer has data
//   in_ready   out  stage can accept
//   in_data    in   producer bundle
//   out_valid  out  out_data is valid
//   out_ready  in   consumer accepts
//   out_data   out  head bundle, FLUSH_VAL when empty
//   occupancy  out  entries held (0..2)

module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int                 DATA_W      = 64,
  parameter logic [DATA_W-1:0]  FLUSH_VAL   = DATA_W'(NOP_BUNDLE),
  parameter bit                 FLUSH_DEFER = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              pend_q, pend_d;

  logic              fl;
  logic              push;
  logic              pop;

  // A pending (deferred) flush fires on the first unfrozen cycle. Freeze
  // outranks flush, so neither a live nor a pending flush acts while frozen.
  assign fl = (flush | pend_q) & ~freeze;

  // No term here looks at out_ready: the skid slot guarantees room for the
  // beat accepted in the same cycle the consumer starts stalling.
  assign in_ready  = (state_q != ST_TWO)   & ~freeze & ~fl;
  assign out_valid = (state_q != ST_EMPTY) & ~freeze & ~fl;

  assign push = in_valid  & in_ready;
  assign pop  = out_valid & out_ready;

  // main_q is forced to FLUSH_VAL whenever the stage empties, so it can
  // drive the output directly without a mux on state.
  assign out_data  = main_q;
  assign occupancy = occ_of(state_q);

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    pend_d  = pend_q;

    if (freeze) begin
      // Everything holds; only the deferred-flush latch may change.
      if (FLUSH_DEFER && flush) begin
        pend_d = 1'b1;
      end
    end else if (fl) begin
      // Handshakes are already masked off by fl, so nothing enters or
      // leaves in this cycle. The skid contents become don't-care.
      state_d = ST_EMPTY;
      main_d  = FLUSH_VAL;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end

        ST_ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            state_d = ST_TWO;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = ST_EMPTY;
            main_d  = FLUSH_VAL;
          end
        end

        ST_TWO: begin
          // in_ready is low here, so a pop only promotes the skid entry.
          if (pop) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end

        default: begin
          state_d = ST_EMPTY;
          main_d  = FLUSH_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= FLUSH_VAL;
      skid_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - scoreboard bench for pipe_stage_buf

module tb_pipe_stage_buf;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         freeze = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;

  logic         a_in_ready, a_out_valid;
  logic [W-1:0] a_out_data;
  logic [1:0]   a_occ;
  logic         b_in_ready, b_out_valid;
  logic [W-1:0] b_out_data;
  logic [1:0]   b_occ;

  int n_vec  = 0;
  int n_miss = 0;

  // Scoreboard for the deferred-flush instance: queue of expected bundles.
  logic [W-1:0] exp_q[$];
  bit           m_pend = 1'b0;

  // Expectations for the non-deferring instance, checked only when enabled.
  bit           chk_b = 1'b0;
  logic         b_exp_valid = 1'b0;
  logic [W-1:0] b_exp_data = '0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(W), .FLUSH_DEFER(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .occupancy(a_occ)
  );

  pipe_stage_buf #(.DATA_W(W), .FLUSH_DEFER(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .occupancy(b_occ)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, sample 1 time unit later, then
  // advance the reference model as the next rising edge will.
  task automatic cycle(input bit iv, input logic [W-1:0] d, input bit ordy,
                       input bit frz, input bit fls);
    bit           mfl, mrdy, mval;
    logic [W-1:0] head;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    freeze    = frz;
    flush     = fls;
    #1;
    mfl  = (fls || m_pend) && !frz;
    mrdy = (exp_q.size() != 2) && !frz && !mfl;
    mval = (exp_q.size() != 0) && !frz && !mfl;
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk("in_ready",  64'(a_in_ready),  64'(mrdy));
    chk("out_valid", 64'(a_out_valid), 64'(mval));
    chk("occupancy", 64'(a_occ),       64'(exp_q.size()));
    chk("out_data",  a_out_data,       head);
    if (chk_b) begin
      chk("b_out_valid", 64'(b_out_valid), 64'(b_exp_valid));
      chk("b_out_data",  b_out_data,        b_exp_data);
    end
    if (frz) begin
      if (fls) m_pend = 1'b1;
    end else if (mfl) begin
      exp_q.delete();
      m_pend = 1'b0;
    end else begin
      if (mval && ordy) void'(exp_q.pop_front());
      if (iv && mrdy) exp_q.push_back(d);
    end
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    freeze    = 1'b0;
    flush     = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_occupancy", 64'(a_occ),       64'd0);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_out_data",  a_out_data,       64'd0);
    chk("rst_in_ready",  64'(a_in_ready),  64'd1);
    chk("rst_b_occ",     64'(b_occ),       64'd0);
    exp_q.delete();
    m_pend = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset, then a single beat appears one cycle later.
    do_reset();
    cycle(1'b1, 64'hA, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Streaming at full rate.
    cycle(1'b1, 64'h1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 64'h2, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 64'h3, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Backpressure fills the skid slot, then drains in order.
    cycle(1'b1, 64'h1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h2, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'hF, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Freeze with a one-cycle flush: deferred on A, discarded on B.
    cycle(1'b1, 64'h5, 1'b0, 1'b0, 1'b0);
    chk_b       = 1'b1;
    b_exp_valid = 1'b0;
    b_exp_data  = 64'h5;
    cycle(1'b1, 64'h6, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
    b_exp_valid = 1'b1;
    cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    chk_b = 1'b0;
    do_reset();

    // Flush while full and a beat is offered: the beat is never taken.
    cycle(1'b1, 64'h8, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h9, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h7, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Reset while full drops both entries.
    cycle(1'b1, 64'h1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h2, 1'b0, 1'b0, 1'b0);
    do_reset();
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 64'hB, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
